cc_cond_unit: RTL and testbench

//  Execute-stage consumer of the 64-bit ALU result. Derives ZF/SF/OF from the ALU

---
 rtl/y86_pkg.sv | 28 ++
 rtl/cc_cond_unit_if.sv | 31 +++
 rtl/cc_cond_unit_flag_gen.sv | 28 ++
 rtl/cc_cond_unit.sv | 76 +++++++
 tb/tb_cc_cond_unit.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 execute-stage definitions: ALU function codes, jXX/cmovXX
// condition codes, the condition-code record and its reset value.
package y86_pkg;

  localparam int W_DEFAULT = 64;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam logic [2:0] CC_RST = 3'b100;

endpackage

// File: rtl/cc_cond_unit_if.sv
// Bundle between the ALU/decode side and the condition-code unit.
// The master drives ALU results and control, the slave (cc_cond_unit)
// returns the condition outcome and the committed flags.
interface cc_cond_if #(
  parameter int W = 64
);
  logic         alu_valid;
  logic [3:0]   alu_fun;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_result;
  logic         set_cc;
  logic         stat_ok;
  logic [3:0]   cond_fun;
  logic         cnd;
  logic         cond_err;
  logic         zf;
  logic         sf;
  logic         of;
  logic         cc_wr;

  modport master (
    output alu_valid, alu_fun, alu_a, alu_b, alu_result, set_cc, stat_ok, cond_fun,
    input  cnd, cond_err, zf, sf, of, cc_wr
  );

  modport slave (
    input  alu_valid, alu_fun, alu_a, alu_b, alu_result, set_cc, stat_ok, cond_fun,
    output cnd, cond_err, zf, sf, of, cc_wr
  );
endinterface

// File: rtl/cc_cond_unit_flag_gen.sv
// Combinational flag generator: derives ZF/SF/OF from the ALU function,
// operands and result. Overflow is taken from the sign bits, so it is
// only meaningful when r really is b+a (ADD) or b-a (SUB).
import y86_pkg::*;

module cc_flag_gen #(
  parameter int W = 64
) (
  input  logic [3:0]   fun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] r,
  output cc_t          flags
);

  // Zero/sign come straight from the result; overflow depends on the op.
  always_comb begin
    flags.zf = (r == '0);
    flags.sf = r[W-1];
    flags.of = 1'b0;
    case (fun)
      ALU_ADD: flags.of = (a[W-1] == b[W-1]) & (r[W-1] != a[W-1]);
      ALU_SUB: flags.of = (a[W-1] != b[W-1]) & (r[W-1] != b[W-1]);
      default: flags.of = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_cond_unit.sv
// Condition-code unit: holds {ZF,SF,OF} written by OPq instructions and
// evaluates the jXX/cmovXX condition.
// Build option: define CC_BYPASS_EN to let cnd see the flags being written
// this cycle (same-cycle forward for a fused OPq+jXX path). Without it, cnd
// always uses the committed CC.
import y86_pkg::*;

module cc_cond_unit #(
  parameter int         W      = 64,
  parameter logic [2:0] CC_RST = y86_pkg::CC_RST
) (
  input  logic     clk,
  input  logic     reset,
  cc_cond_if.slave bus
);

  cc_t  new_cc;
  cc_t  cc_q;
  cc_t  cc_src;
  logic upd;
  logic cc_wr_q;
  logic cnd_c;
  logic err_c;

  cc_flag_gen #(.W(W)) u_flag_gen (
    .fun   (bus.alu_fun),
    .a     (bus.alu_a),
    .b     (bus.alu_b),
    .r     (bus.alu_result),
    .flags (new_cc)
  );

  // Only a valid, AOK, flag-setting instruction with a defined ALU op may touch CC.
  assign upd = bus.alu_valid & bus.set_cc & bus.stat_ok & (bus.alu_fun <= ALU_XOR);

  // CC register and write-strobe flop; reset drops any update in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cc_q    <= cc_t'(CC_RST);
      cc_wr_q <= 1'b0;
    end else begin
      if (upd) cc_q <= new_cc;
      cc_wr_q <= upd;
    end
  end

`ifdef CC_BYPASS_EN
  assign cc_src = upd ? new_cc : cc_q;
`else
  assign cc_src = cc_q;
`endif

  // Condition decoder; undefined cond_fun codes never take the branch.
  always_comb begin
    cnd_c = 1'b0;
    err_c = 1'b0;
    case (bus.cond_fun)
      C_ALWAYS: cnd_c = 1'b1;
      C_LE:     cnd_c = (cc_src.sf ^ cc_src.of) | cc_src.zf;
      C_L:      cnd_c = cc_src.sf ^ cc_src.of;
      C_E:      cnd_c = cc_src.zf;
      C_NE:     cnd_c = ~cc_src.zf;
      C_GE:     cnd_c = ~(cc_src.sf ^ cc_src.of);
      C_G:      cnd_c = ~(cc_src.sf ^ cc_src.of) & ~cc_src.zf;
      default:  err_c = 1'b1;
    endcase
  end

  assign bus.cnd      = cnd_c;
  assign bus.cond_err = err_c;
  assign bus.zf       = cc_q.zf;
  assign bus.sf       = cc_q.sf;
  assign bus.of       = cc_q.of;
  assign bus.cc_wr    = cc_wr_q;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Self-checking bench for cc_cond_unit: directed scenarios followed by
// randomized OPq/jXX traffic against a behavioural reference model that
// works from signed arithmetic on the operands rather than sign bits.
module tb_cc_cond_unit;

  localparam int W = 64;
  localparam logic signed [65:0] SMAX = 66'sd9223372036854775807;
  localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic mz, ms, mo, mwr;

  cc_cond_if #(.W(W)) bus ();

  cc_cond_unit #(.W(W), .CC_RST(3'b100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] correctResult(input logic [3:0] fun, input logic [63:0] a,
                                                input logic [63:0] b);
    case (fun)
      4'd0:    return b + a;
      4'd1:    return b - a;
      4'd2:    return b & a;
      4'd3:    return b ^ a;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Reference flags: overflow means the true signed result does not fit in 64 bits.
  task automatic modelFlags(input logic [3:0] fun, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] r, output logic z, output logic s,
                            output logic o);
    logic signed [65:0] sa, sb, t;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    t  = '0;
    if (fun == 4'd0) t = sb + sa;
    else if (fun == 4'd1) t = sb - sa;
    z = (r == 64'd0);
    s = ($signed(r) < 0);
    o = ((fun == 4'd0) || (fun == 4'd1)) && ((t > SMAX) || (t < SMIN));
  endtask

  // Reference condition: "less" is SF xor OF, as in signed compare after SUB.
  task automatic modelCnd(input logic [3:0] cf, input logic z, input logic s, input logic o,
                          output logic c, output logic e);
    logic less;
    less = s ^ o;
    e = (cf > 4'd6);
    c = 1'b0;
    if (cf == 4'd0) c = 1'b1;
    else if (cf == 4'd1) c = less || z;
    else if (cf == 4'd2) c = less;
    else if (cf == 4'd3) c = z;
    else if (cf == 4'd4) c = !z;
    else if (cf == 4'd5) c = !less;
    else if (cf == 4'd6) c = !less && !z;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkModelCc();
    checkOutput("zf", 64'(bus.zf), 64'(mz));
    checkOutput("sf", 64'(bus.sf), 64'(ms));
    checkOutput("of", 64'(bus.of), 64'(mo));
    checkOutput("cc_wr", 64'(bus.cc_wr), 64'(mwr));
  endtask

  // Drive one instruction, check cnd before the edge and CC after it.
  task automatic applyStimulus(input logic [3:0] fun, input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] r, input logic valid, input logic setcc,
                               input logic ok, input logic [3:0] cf);
    logic nz, ns, no, sz, ss, so, ec, ee, upd;
    bus.alu_fun    = fun;
    bus.alu_a      = a;
    bus.alu_b      = b;
    bus.alu_result = r;
    bus.alu_valid  = valid;
    bus.set_cc     = setcc;
    bus.stat_ok    = ok;
    bus.cond_fun   = cf;
    #1;
    modelFlags(fun, a, b, r, nz, ns, no);
    upd = valid && setcc && ok && (fun <= 4'd3);
    sz = mz; ss = ms; so = mo;
`ifdef CC_BYPASS_EN
    if (upd) begin
      sz = nz; ss = ns; so = no;
    end
`endif
    modelCnd(cf, sz, ss, so, ec, ee);
    checkOutput("cnd", 64'(bus.cnd), 64'(ec));
    checkOutput("cond_err", 64'(bus.cond_err), 64'(ee));
    @(posedge clk);
    #1;
    if (upd) begin
      mz = nz; ms = ns; mo = no;
    end
    mwr = upd;
    checkModelCc();
  endtask

  // Look at cnd for a given cond_fun with no instruction in flight.
  task automatic probeCond(input logic [3:0] cf, input logic expCnd, input string tag);
    bus.alu_valid = 1'b0;
    bus.cond_fun  = cf;
    #1;
    checkOutput(tag, 64'(bus.cnd), 64'(expCnd));
  endtask

  function automatic logic [63:0] pickOperand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return MAXP;
      2:       return MINN;
      3:       return ONES;
      4:       return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    vectors = 0;
    miscompares = 0;
    mz = 1'b1; ms = 1'b0; mo = 1'b0; mwr = 1'b0;
    reset = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_fun = 4'd0; bus.alu_a = '0; bus.alu_b = '0;
    bus.alu_result = '0; bus.set_cc = 1'b0; bus.stat_ok = 1'b1; bus.cond_fun = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Get some non-reset state, then reset mid-cycle.
    applyStimulus(4'd1, 64'd3, 64'd1, 64'd1 - 64'd3, 1'b1, 1'b1, 1'b1, 4'd0);
    #2;
    reset = 1'b1;
    bus.cond_fun = 4'd3;
    #1;
    mz = 1'b1; ms = 1'b0; mo = 1'b0; mwr = 1'b0;
    checkOutput("rst_zf", 64'(bus.zf), 64'd1);
    checkOutput("rst_sf", 64'(bus.sf), 64'd0);
    checkOutput("rst_of", 64'(bus.of), 64'd0);
    checkOutput("rst_cc_wr", 64'(bus.cc_wr), 64'd0);
    checkOutput("rst_cnd_e", 64'(bus.cnd), 64'd1);
    // An update offered while reset is held must be discarded.
    bus.alu_fun = 4'd3; bus.alu_a = ONES; bus.alu_b = 64'd0; bus.alu_result = ONES;
    bus.alu_valid = 1'b1; bus.set_cc = 1'b1; bus.stat_ok = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_hold_zf", 64'(bus.zf), 64'd1);
    checkOutput("rst_hold_sf", 64'(bus.sf), 64'd0);
    checkOutput("rst_hold_cc_wr", 64'(bus.cc_wr), 64'd0);
    bus.alu_valid = 1'b0;
    reset = 1'b0;

    // SUB equal operands -> zero.
    applyStimulus(4'd1, 64'd5, 64'd5, 64'd0, 1'b1, 1'b1, 1'b1, 4'd3);
    checkOutput("sub0_zf", 64'(bus.zf), 64'd1);
    checkOutput("sub0_sf", 64'(bus.sf), 64'd0);
    checkOutput("sub0_of", 64'(bus.of), 64'd0);
    checkOutput("sub0_cc_wr", 64'(bus.cc_wr), 64'd1);
    probeCond(4'd3, 1'b1, "sub0_cnd_e");

    // ADD positive overflow.
    applyStimulus(4'd0, 64'd1, MAXP, MINN, 1'b1, 1'b1, 1'b1, 4'd0);
    checkOutput("addov_of", 64'(bus.of), 64'd1);
    checkOutput("addov_sf", 64'(bus.sf), 64'd1);
    checkOutput("addov_zf", 64'(bus.zf), 64'd0);
    probeCond(4'd2, 1'b0, "addov_cnd_l");
    probeCond(4'd1, 1'b0, "addov_cnd_le");

    // SUB negative overflow.
    applyStimulus(4'd1, 64'd1, MINN, MAXP, 1'b1, 1'b1, 1'b1, 4'd0);
    checkOutput("subov_of", 64'(bus.of), 64'd1);
    checkOutput("subov_sf", 64'(bus.sf), 64'd0);
    probeCond(4'd2, 1'b1, "subov_cnd_l");

    // Non-AOK status and reserved ALU op must leave CC alone.
    applyStimulus(4'd3, ONES, 64'd0, ONES, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("stat_cc_wr", 64'(bus.cc_wr), 64'd0);
    checkOutput("stat_sf", 64'(bus.sf), 64'd0);
    checkOutput("stat_of", 64'(bus.of), 64'd1);
    applyStimulus(4'd7, ONES, 64'd0, ONES, 1'b1, 1'b1, 1'b1, 4'd0);
    checkOutput("rsv_cc_wr", 64'(bus.cc_wr), 64'd0);
    checkOutput("rsv_sf", 64'(bus.sf), 64'd0);

    // MINN alone sets only SF.
    applyStimulus(4'd2, ONES, MINN, MINN, 1'b1, 1'b1, 1'b1, 4'd0);
    checkOutput("min_sf", 64'(bus.sf), 64'd1);
    checkOutput("min_zf", 64'(bus.zf), 64'd0);
    checkOutput("min_of", 64'(bus.of), 64'd0);

    // Undefined cond_fun.
    bus.alu_valid = 1'b0;
    bus.cond_fun = 4'd9;
    #1;
    checkOutput("cf9_cnd", 64'(bus.cnd), 64'd0);
    checkOutput("cf9_err", 64'(bus.cond_err), 64'd1);

    // Same-cycle visibility of a zero result (old CC has zf=0).
    bus.alu_fun = 4'd1; bus.alu_a = 64'd7; bus.alu_b = 64'd7; bus.alu_result = 64'd0;
    bus.alu_valid = 1'b1; bus.set_cc = 1'b1; bus.stat_ok = 1'b1; bus.cond_fun = 4'd3;
    #1;
`ifdef CC_BYPASS_EN
    checkOutput("bypass_cnd", 64'(bus.cnd), 64'd1);
`else
    checkOutput("nobypass_cnd", 64'(bus.cnd), 64'd0);
`endif
    applyStimulus(4'd1, 64'd7, 64'd7, 64'd0, 1'b1, 1'b1, 1'b1, 4'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  fun;
      logic [63:0] a, b, r;
      fun = 4'($urandom_range(0, 5));
      a = pickOperand();
      b = pickOperand();
      r = correctResult(fun, a, b);
      applyStimulus(fun, a, b, r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 5) != 0), 4'($urandom_range(0, 9)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
